// File: rtl/bcd_conv_arbiter_if.sv
// Requester-side bus of the shared BCD converter arbiter.
// master = requesters (drive req/val), slave = the arbiter.
interface bcd_conv_arbiter_if;
  logic [1:0] req;
  logic [4:0] val0;
  logic [4:0] val1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       err;
  logic       busy;

  modport master (
    output req, val0, val1,
    input  gnt, done, tens, ones, err, busy
  );

  modport slave (
    input  req, val0, val1,
    output gnt, done, tens, ones, err, busy
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 5-bit binary-to-BCD
// converter between two requesters: grant, drive converter, capture, respond.
module bcd_conv_arbiter (
  input  logic                  clk,
  input  logic                  rst,
  bcd_conv_arbiter_if.slave     bus,
  output logic [4:0]            cv_in,
  input  logic [3:0]            cv_tens,
  input  logic [3:0]            cv_ones
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       last;
  logic       cur;
  logic       win;
  logic [4:0] hold;
  logic       err_pending;
  logic [3:0] tens_q;
  logic [3:0] ones_q;

  // Outputs decode only from registers, so nothing combinational leaks from req/val.
  always_comb begin
    state_nxt = state;
    win       = 1'b0;
    bus.gnt   = 2'b00;
    bus.done  = 2'b00;
    bus.err   = 1'b0;
    bus.busy  = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = DRIVE;
          win       = (&bus.req) ? ~last : bus.req[1];
        end
      end
      DRIVE: begin
        state_nxt = RESP;
        bus.gnt   = cur ? 2'b10 : 2'b01;
        bus.busy  = 1'b1;
      end
      RESP: begin
        state_nxt = IDLE;
        bus.done  = cur ? 2'b10 : 2'b01;
        bus.err   = err_pending;
        bus.busy  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset leaves last=1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      cur         <= 1'b0;
      hold        <= 5'd0;
      err_pending <= 1'b0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (|bus.req)) begin
        hold <= win ? bus.val1 : bus.val0;
        last <= win;
        cur  <= win;
      end
      if (state == DRIVE) begin
        tens_q      <= cv_tens;
        ones_q      <= cv_ones;
        err_pending <= (hold > 5'd19);
      end
    end
  end

  assign cv_in    = hold;
  assign bus.tens = tens_q;
  assign bus.ones = ones_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed plan plus random
// transactions against an arithmetic reference of grant order and BCD result.
module tb_bcd_conv_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] cv_in;
  logic [3:0] cv_tens;
  logic [3:0] cv_ones;

  bcd_conv_arbiter_if bus ();

  bcd_conv_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .cv_in   (cv_in),
    .cv_tens (cv_tens),
    .cv_ones (cv_ones)
  );

  // Behavioural stand-in for the shared converter; out-of-range inputs still divide.
  assign cv_tens = 4'(cv_in / 5'd10);
  assign cv_ones = 4'(cv_in % 5'd10);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_model = 1;
  int done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  32'(bus.gnt),  32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_tens"}, 32'(bus.tens), 32'd0);
    chk({tag, "_ones"}, 32'(bus.ones), 32'd0);
    chk({tag, "_err"},  32'(bus.err),  32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_cvin"}, 32'(cv_in),    32'd0);
  endtask

  // One full transaction: request, grant, response, back to idle.
  task automatic conv_once(input logic [1:0] r, input logic [4:0] v0, input logic [4:0] v1,
                           input bit hold_req, input bit mutate);
    int         w;
    int         v;
    logic [1:0] oh;
    bus.req  = r;
    bus.val0 = v0;
    bus.val1 = v1;
    w  = (r == 2'b11) ? (1 - last_model) : (r[1] ? 1 : 0);
    v  = (w == 1) ? int'(v1) : int'(v0);
    oh = (w == 1) ? 2'b10 : 2'b01;
    last_model = w;
    step();
    chk("gnt",       32'(bus.gnt),  32'(oh));
    chk("gnt_busy",  32'(bus.busy), 32'd1);
    chk("gnt_done",  32'(bus.done), 32'd0);
    chk("cv_in",     32'(cv_in),    32'(v));
    if (!hold_req) bus.req[w] = 1'b0;
    if (mutate) begin
      if (w == 1) bus.val1 = ~v1;
      else        bus.val0 = ~v0;
    end
    step();
    chk("done",      32'(bus.done), 32'(oh));
    chk("done_gnt",  32'(bus.gnt),  32'd0);
    chk("tens",      32'(bus.tens), 32'((v / 10) % 16));
    chk("ones",      32'(bus.ones), 32'(v % 10));
    chk("err",       32'(bus.err),  32'(v > 19));
    done_cyc = cyc;
    step();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int prev_done;
    int v;
    logic [1:0] r;
    rst      = 1'b1;
    bus.req  = 2'b00;
    bus.val0 = 5'd0;
    bus.val1 = 5'd0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk_all_zero("post_reset");

    // Single requester 0 with 13.
    conv_once(2'b01, 5'd13, 5'd0, 1'b0, 1'b0);
    // Requester 1 with 20 flags Err.
    conv_once(2'b10, 5'd0, 5'd20, 1'b0, 1'b0);

    // Reset during DRIVE drops the request and restores last=1.
    bus.req  = 2'b01;
    bus.val0 = 5'd9;
    step();
    chk("pre_rst_gnt", 32'(bus.gnt), 32'd1);
    bus.req = 2'b00;
    rst = 1'b1;
    step();
    chk_all_zero("mid_rst");
    rst = 1'b0;
    last_model = 1;
    step();
    chk("after_rst_done", 32'(bus.done), 32'd0);

    // Both held: grants alternate 0,1,0,1 with Dones 3 cycles apart.
    for (int i = 0; i < 4; i++) begin
      prev_done = done_cyc;
      conv_once(2'b11, 5'd7, 5'd19, 1'b1, 1'b0);
      if (i > 0) chk("done_spacing", 32'(done_cyc - prev_done), 32'd3);
    end
    bus.req = 2'b00;

    // Req[0] pulsed only while busy is never granted.
    bus.req  = 2'b10;
    bus.val1 = 5'd4;
    step();
    chk("pulse_gnt1", 32'(bus.gnt), 32'd2);
    bus.req = 2'b01;
    step();
    bus.req = 2'b00;
    chk("pulse_done1", 32'(bus.done), 32'd2);
    step();
    step();
    chk("pulse_nogrant", 32'(bus.gnt), 32'd0);
    chk("pulse_idle",    32'(bus.busy), 32'd0);
    last_model = 1;

    // Value changed after grant must not disturb the result.
    conv_once(2'b01, 5'd17, 5'd0, 1'b0, 1'b1);
    conv_once(2'b10, 5'd0, 5'd11, 1'b0, 1'b1);

    // Full legal sweep on each requester.
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 20; s++) begin
        conv_once((k == 1) ? 2'b10 : 2'b01, 5'(s), 5'(s), 1'b0, 1'b0);
        chk("sweep_sum", 32'(int'(bus.tens) * 10 + int'(bus.ones)), 32'(s));
      end
    end

    // Random request patterns and full 5-bit values.
    for (int i = 0; i < 40; i++) begin
      r = 2'($urandom_range(1, 3));
      v = int'($urandom_range(0, 31));
      conv_once(r, 5'(v), 5'($urandom_range(0, 31)), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
